// File: rtl/dispatch_pkg.sv
// Shared constants and FSM encoding for the tag dispatcher.
package dispatch_pkg;

  localparam int TAG_SZ_DEF     = 5;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int MAX_BEATS_DEF  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2
  } disp_state_t;

  // Beat counter must hold MAX_BEATS itself without wrapping.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/tag_onehot.sv
// Combinational decode of a core-index tag into a one-hot core select.
module tag_onehot #(
  parameter int TAG_SZ = 5
) (
  input  logic [TAG_SZ-1:0]      tag,
  output logic [2**TAG_SZ-1:0]   onehot
);

  for (genvar gi = 0; gi < 2**TAG_SZ; gi++) begin : g_dec
    assign onehot[gi] = (tag == TAG_SZ'(gi));
  end

endmodule

// File: rtl/tag_dispatch.sv
// Routes one snooped packet stream to the core named by the arbitration tag.
// Optional per-packet statistics are enabled with TAG_DISPATCH_STATS_EN.
module tag_dispatch
  import dispatch_pkg::*;
#(
  parameter int TAG_SZ     = TAG_SZ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BEATS  = MAX_BEATS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TAG_SZ-1:0]       tag,
  input  logic                    rdy,
  output logic                    ack,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   core_tdata,
  output logic                    core_tvalid,
  output logic                    core_tlast,
  output logic [2**TAG_SZ-1:0]    core_sel,
  input  logic [2**TAG_SZ-1:0]    core_tready,
`ifdef TAG_DISPATCH_STATS_EN
  output logic [31:0]             pkt_cnt,
  output logic [31:0]             drop_cnt,
`endif
  output logic                    drop_err
);

  localparam int N     = 2**TAG_SZ;
  localparam int CNT_W = cnt_width(MAX_BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BEATS);

  disp_state_t       state_reg;
  logic [TAG_SZ-1:0] tag_q;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic              drop_err_reg;
  logic [N-1:0]      sel_dec;
  logic              hs;
  logic              at_limit;

  tag_onehot #(.TAG_SZ(TAG_SZ)) u_tag_onehot (
    .tag    (tag_q),
    .onehot (sel_dec)
  );

  assign hs       = s_tvalid && s_tready;
  assign at_limit = (beat_cnt_reg == LAST_CNT);

  assign core_tdata = s_tdata;
  assign core_tlast = s_tlast;
  assign drop_err   = drop_err_reg;

  // The beat that would overflow the packet is never shown to the core,
  // so an oversize packet delivers exactly MAX_BEATS-1 beats.
  always_comb begin
    ack         = 1'b0;
    s_tready    = 1'b0;
    core_tvalid = 1'b0;
    core_sel    = '0;
    case (state_reg)
      IDLE: ack = rdy && rst;
      XFER: begin
        core_sel    = sel_dec;
        s_tready    = core_tready[tag_q];
        core_tvalid = s_tvalid && !(at_limit && !s_tlast);
      end
      DROP: s_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      tag_q        <= '0;
      beat_cnt_reg <= '0;
      drop_err_reg <= 1'b0;
    end else begin
      drop_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rdy) begin
            tag_q        <= tag;
            beat_cnt_reg <= '0;
            state_reg    <= XFER;
          end
        end
        XFER: begin
          if (hs) begin
            if (beat_cnt_reg != MAX_CNT) begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
            if (s_tlast) begin
              state_reg <= IDLE;
            end else if (at_limit) begin
              state_reg    <= DROP;
              drop_err_reg <= 1'b1;
            end
          end
        end
        DROP: begin
          if (hs && s_tlast) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef TAG_DISPATCH_STATS_EN
  logic [31:0] pkt_cnt_reg;
  logic [31:0] drop_cnt_reg;

  assign pkt_cnt  = pkt_cnt_reg;
  assign drop_cnt = drop_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else if (state_reg == XFER && hs) begin
      if (s_tlast) begin
        pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
      end else if (at_limit) begin
        drop_cnt_reg <= drop_cnt_reg + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tag_dispatch.sv
// Randomized self-checking bench for tag_dispatch against a packet-level model.
module tb_tag_dispatch;

  localparam int TSZ   = 5;
  localparam int DW    = 64;
  localparam int MAX_B = 4;
  localparam int NC    = 2**TSZ;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [TSZ-1:0]  tag = '0;
  logic            rdy = 1'b0;
  logic            ack;
  logic [DW-1:0]   s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tlast = 1'b0;
  logic            s_tready;
  logic [DW-1:0]   core_tdata;
  logic            core_tvalid;
  logic            core_tlast;
  logic [NC-1:0]   core_sel;
  logic [NC-1:0]   core_tready = '0;
  logic            drop_err;
`ifdef TAG_DISPATCH_STATS_EN
  logic [31:0]     pkt_cnt;
  logic [31:0]     drop_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  int m_pkt = 0;
  int m_drop = 0;

  tag_dispatch #(.TAG_SZ(TSZ), .DATA_WIDTH(DW), .MAX_BEATS(MAX_B)) dut (
    .clk         (clk),
    .rst         (rst),
    .tag         (tag),
    .rdy         (rdy),
    .ack         (ack),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .core_tdata  (core_tdata),
    .core_tvalid (core_tvalid),
    .core_tlast  (core_tlast),
    .core_sel    (core_sel),
    .core_tready (core_tready),
`ifdef TAG_DISPATCH_STATS_EN
    .pkt_cnt     (pkt_cnt),
    .drop_cnt    (drop_cnt),
`endif
    .drop_err    (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_ack"}, ack, 0);
    chk({pfx, "_srdy"}, s_tready, 0);
    chk({pfx, "_cvld"}, core_tvalid, 0);
    chk({pfx, "_sel"}, core_sel, 0);
    chk({pfx, "_derr"}, drop_err, 0);
  endtask

  // Model: a packet of len beats delivers all beats if len <= MAX_B,
  // otherwise only the first MAX_B-1, with a single drop_err pulse.
  // mode 0: full rate, 1: target core ready toggles 1/0, 2: random valid/ready.
  task automatic send_pkt(input int t, input int len, input int mode, input int gap);
    logic [63:0] pdata [0:15];
    logic [63:0] got [$];
    logic [31:0] exp_sel;
    int b, cyc, nfwd;
    bit in_drop, exp_derr, dropped, exp_rdy;
    exp_sel = 32'd1 << t;
    for (int i = 0; i < len; i++) pdata[i] = {$urandom, $urandom};
    dropped = (len > MAX_B);
    nfwd = dropped ? MAX_B - 1 : len;
    for (int i = 0; i < gap; i++) begin
      rdy = 1'b0; tag = TSZ'($urandom); s_tvalid = 1'($urandom);
      core_tready = $urandom;
      @(negedge clk);
      chk_quiet("idle");
      @(posedge clk); #1;
    end
    rdy = 1'b1; tag = TSZ'(t); s_tvalid = 1'($urandom); s_tlast = 1'b0;
    core_tready = $urandom;
    @(negedge clk);
    chk("acc_ack", ack, 1);
    chk("acc_srdy", s_tready, 0);
    chk("acc_cvld", core_tvalid, 0);
    chk("acc_sel", core_sel, 0);
    chk("acc_derr", drop_err, 0);
    @(posedge clk); #1;
    b = 0; cyc = 0; in_drop = 0; exp_derr = 0;
    while (b < len && cyc < 200) begin
      rdy = 1'($urandom); tag = TSZ'($urandom);
      s_tdata = pdata[b]; s_tlast = (b == len - 1);
      s_tvalid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      core_tready = $urandom;
      core_tready[t] = (mode == 1) ? (cyc % 2 == 0) :
                       (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      exp_rdy = in_drop ? 1'b1 : core_tready[t];
      @(negedge clk);
      chk("busy_ack", ack, 0);
      chk("s_tready", s_tready, exp_rdy);
      chk("drop_err", drop_err, exp_derr);
      chk("core_tlast", core_tlast, s_tlast);
      if (in_drop) begin
        chk("drop_cvld", core_tvalid, 0);
        chk("drop_sel", core_sel, 0);
      end else begin
        chk("core_sel", core_sel, exp_sel);
        chk("core_tvalid", core_tvalid, s_tvalid && (b < nfwd));
        if (core_tvalid) chk("core_tdata", core_tdata, pdata[b]);
        if (core_tvalid && core_sel[t] && core_tready[t]) got.push_back(core_tdata);
      end
      exp_derr = 0;
      if (s_tvalid && exp_rdy) begin
        if (!in_drop && dropped && b == MAX_B - 1) begin
          in_drop = 1; exp_derr = 1;
        end
        b++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; rdy = 1'b0;
    chk("beats_consumed", b, len);
    chk("n_fwd", got.size(), nfwd);
    for (int i = 0; i < got.size() && i < nfwd; i++) chk("fwd_data", got[i], pdata[i]);
    if (dropped) m_drop++; else m_pkt++;
    $display("pkt tag=%0d len=%0d mode=%0d gap=%0d fwd=%0d dropped=%0d cycles=%0d",
             t, len, mode, gap, got.size(), dropped, cyc);
  endtask

  task automatic chk_stats(input string pfx);
`ifdef TAG_DISPATCH_STATS_EN
    @(negedge clk);
    chk({pfx, "_pkt_cnt"}, pkt_cnt, m_pkt);
    chk({pfx, "_drop_cnt"}, drop_cnt, m_drop);
    $display("stats %s pkt_cnt=%0d drop_cnt=%0d", pfx, pkt_cnt, drop_cnt);
    @(posedge clk); #1;
`else
    $display("stats %s not built", pfx);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; tag = 5'd3; s_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1; rdy = 1'b0; s_tvalid = 1'b0;
    @(posedge clk); #1;
    chk_stats("after_reset");

    send_pkt(3, 4, 0, 0);
    send_pkt(3, 4, 1, 1);
    send_pkt(9, 6, 0, 0);
    send_pkt(12, 4, 0, 0);
    send_pkt(0, 5, 2, 0);
    send_pkt(31, 1, 0, 2);

    // Reset in the middle of a packet to core 7.
    rdy = 1'b1; tag = 5'd7; core_tready = '1;
    @(posedge clk); #1;
    rdy = 1'b0; s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 64'h1111;
    @(posedge clk); #1;
    s_tdata = 64'h2222; rdy = 1'b1;
    @(negedge clk);
    chk("pre_rst_srdy", s_tready, 1);
    chk("pre_rst_sel", core_sel, 32'h80);
    #2 rst = 1'b0;
    #1 chk_quiet("async_rst");
    $display("reset asserted mid-XFER at %0t", $time);
    @(posedge clk); @(negedge clk);
    chk_quiet("held_rst");
    rst = 1'b1; rdy = 1'b0; s_tvalid = 1'b0;
    m_pkt = 0; m_drop = 0;
    @(posedge clk); #1;

    send_pkt(5, 4, 0, 0);
    send_pkt(1, 2, 2, 0);
    send_pkt(2, 3, 0, 1);
    send_pkt(6, 7, 2, 0);
    chk_stats("three_good_one_drop");

    for (int k = 0; k < 20; k++) begin
      send_pkt($urandom_range(0, NC - 1), $urandom_range(1, 9),
               $urandom_range(0, 2), $urandom_range(0, 2));
    end
    chk_stats("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tag_dispatch.md
TAG_DISPATCH -- requirements
Module: tag_dispatch

Interface
REQ-001 SHALL have parameter TAG_SZ, default 5, the width of the core-index tag; N = 2**TAG_SZ cores.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the packet data width.
REQ-003 SHALL have parameter MAX_BEATS, default 256, the maximum beats per packet before the packet is dropped.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port tag  input  TAG_SZ  index of a ready core, from the arbitration-tree root.
REQ-007 SHALL have port rdy  input  1  tag valid (some core is ready).
REQ-008 SHALL have port ack  output  1  tag consumed this cycle.
REQ-009 SHALL have ports s_tdata (input, DATA_WIDTH), s_tvalid (input, 1), s_tlast (input, 1) and s_tready (output, 1): the snooped packet stream.
REQ-010 SHALL have ports core_tdata (output, DATA_WIDTH), core_tvalid (output, 1), core_tlast (output, 1): the stream broadcast to all cores.
REQ-011 SHALL have port core_sel  output  N  one-hot write enable to the selected core.
REQ-012 SHALL have port core_tready  input  N  per-core ready.
REQ-013 SHALL have port drop_err  output  1  one-cycle pulse when an oversize packet is dropped.

Function
REQ-014 SHALL implement FSM states IDLE, XFER and DROP.
REQ-015 IDLE: ack SHALL equal rdy combinationally; s_tready=0, core_tvalid=0, core_sel=0.
REQ-016 IDLE with rdy=1 SHALL latch tag into tag_q, clear the beat counter and enter XFER the next cycle.
REQ-017 XFER: core_sel SHALL be the one-hot of tag_q, s_tready SHALL be core_tready[tag_q], core_tvalid SHALL be s_tvalid, and core_tdata/core_tlast SHALL be passed through; zero added latency.
REQ-018 XFER: the beat counter SHALL increment on each s_tvalid&&s_tready handshake; a handshake with s_tlast=1 SHALL return to IDLE.
REQ-019 XFER: a handshake with s_tlast=0 when the counter equals MAX_BEATS-1 SHALL enter DROP and pulse drop_err for one cycle.
REQ-020 A handshake with s_tlast=1 on beat MAX_BEATS SHALL complete normally: no drop, no drop_err.
REQ-021 DROP: s_tready=1, core_tvalid=0, core_sel=0; beats SHALL be discarded until a handshake with s_tlast=1, then the FSM SHALL go to IDLE.
REQ-022 ack SHALL be 0 in XFER and DROP regardless of rdy; tag changes while not in IDLE SHALL be ignored.
REQ-023 Back-to-back packets SHALL incur exactly one IDLE cycle between the tlast handshake and the next first beat.
REQ-024 The beat counter SHALL be clog2(MAX_BEATS)+1 bits wide and SHALL never wrap.

Reset
REQ-025 While rst=0 the block SHALL be in IDLE with tag_q=0, counter=0, core_sel=0, ack=0, s_tready=0, core_tvalid=0 and drop_err=0.
REQ-026 Reset asserted mid-XFER or mid-DROP SHALL abandon the packet immediately; no partial-state recovery.

Configuration
REQ-027 With TAG_DISPATCH_STATS_EN defined, the block SHALL add outputs pkt_cnt[31:0] (completed packets) and drop_cnt[31:0] (dropped packets).
REQ-028 Both counters SHALL be reset to 0 by rst and SHALL wrap modulo 2^32.
REQ-029 Without TAG_DISPATCH_STATS_EN, those ports and registers SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-030 FSM state encodings and the default TAG_SZ/DATA_WIDTH constants SHALL live in shared package dispatch_pkg.
REQ-031 The tag-to-one-hot decode SHALL be sub-module tag_onehot (TAG_SZ in, 2**TAG_SZ out, combinational).

Verification
REQ-032 Reset, then rdy=1 with tag=3 -> ack=1 for one cycle; then core_sel=0x00000008; a 4-beat packet reaches core 3; FSM returns to IDLE.
REQ-033 core_tready[3] toggled 1/0 every cycle during a 4-beat packet -> s_tready follows it; exactly 4 handshakes; no beat lost or duplicated.
REQ-034 MAX_BEATS=4, 6-beat packet -> 3 beats forwarded, drop_err pulses once, remaining beats consumed with core_tvalid=0, IDLE after tlast.
REQ-035 MAX_BEATS=4, packet with tlast on beat 4 -> all 4 beats forwarded, drop_err stays 0.
REQ-036 rst driven low on beat 2 of XFER -> outputs reach reset values asynchronously; after release, rdy=1 with tag=5 is acked and served normally.
REQ-037 TAG_DISPATCH_STATS_EN defined, 3 good packets and 1 oversize packet -> pkt_cnt=3, drop_cnt=1.
